// File: rtl/comparator_selftest_pkg.sv
// Shared definitions for the comparator self-test engine: FSM encoding and
// error-counter sizing. Optional build macro: COMPARATOR_SELFTEST_STOP_ON_FAIL_EN.
package comparator_selftest_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int                     ERR_COUNT_W   = 8;
    localparam logic [ERR_COUNT_W-1:0] ERR_COUNT_SAT = 8'd255;

    function automatic logic [ERR_COUNT_W-1:0] sat_inc(input logic [ERR_COUNT_W-1:0] v);
        return (v == ERR_COUNT_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/comparator_selftest_golden.sv
// Combinational reference magnitude comparator (unsigned) used as the
// golden model inside the self-test engine.
module cmp_golden #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_gt,
    output logic             o_lt,
    output logic             o_eq
);

    assign o_gt = (i_a > i_b);
    assign o_lt = (i_a < i_b);
    assign o_eq = (i_a == i_b);

endmodule

// File: rtl/comparator_selftest.sv
// Hardware self-test engine: sweeps every {a,b} into an external comparator
// and checks its responses. `define COMPARATOR_SELFTEST_STOP_ON_FAIL_EN to end
// the sweep at the first mismatch with the failing vector left on a_out/b_out.
module comparator_selftest
    import comparator_selftest_pkg::*;
#(
    parameter int WIDTH         = 2,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [WIDTH-1:0]       a_out,
    output logic [WIDTH-1:0]       b_out,
    input  logic                   a_gt_b,
    input  logic                   a_lt_b,
    input  logic                   a_eq_b,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_COUNT_W-1:0] err_count,
    output logic                   fail_valid,
    output logic [WIDTH-1:0]       fail_a,
    output logic [WIDTH-1:0]       fail_b
);

    localparam int               VEC_W    = 2 * WIDTH;
    localparam int               CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t                 r_state;
    logic [VEC_W-1:0]       r_vec;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic [ERR_COUNT_W-1:0] r_err;
    logic                   r_fail_valid;
    logic [WIDTH-1:0]       r_fail_a;
    logic [WIDTH-1:0]       r_fail_b;

    logic                   w_gt;
    logic                   w_lt;
    logic                   w_eq;
    logic                   w_mismatch;
    logic                   w_last;
    logic                   w_stop;
    logic [ERR_COUNT_W-1:0] w_err_next;

    cmp_golden #(.WIDTH(WIDTH)) u_golden (
        .i_a  (r_vec[VEC_W-1:WIDTH]),
        .i_b  (r_vec[WIDTH-1:0]),
        .o_gt (w_gt),
        .o_lt (w_lt),
        .o_eq (w_eq)
    );

    // Any differing response bit makes the whole vector one mismatch.
    assign w_mismatch = (a_gt_b != w_gt) | (a_lt_b != w_lt) | (a_eq_b != w_eq);
    assign w_err_next = w_mismatch ? sat_inc(r_err) : r_err;
    assign w_last     = &r_vec;
`ifdef COMPARATOR_SELFTEST_STOP_ON_FAIL_EN
    assign w_stop     = w_last | w_mismatch;
`else
    assign w_stop     = w_last;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_vec        <= '0;
            r_cnt        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_err        <= '0;
                        r_pass       <= 1'b0;
                        r_fail_valid <= 1'b0;
                        r_fail_a     <= '0;
                        r_fail_b     <= '0;
                        r_vec        <= '0;
                        r_cnt        <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_a     <= r_vec[VEC_W-1:WIDTH];
                        r_fail_b     <= r_vec[WIDTH-1:0];
                    end
                    if (w_stop) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (w_err_next == '0);
                        r_state <= ST_DONE;
                    end else begin
                        r_vec   <= r_vec + 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_out      = r_vec[VEC_W-1:WIDTH];
    assign b_out      = r_vec[WIDTH-1:0];
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign fail_valid = r_fail_valid;
    assign fail_a     = r_fail_a;
    assign fail_b     = r_fail_b;

endmodule
